// File: rtl/ysyx_25040111_lsu_pkg.sv
// Shared encodings for the ysyx_25040111 load/store unit: access sizes, FSM states and the
// byte-strobe table.
package ysyx_25040111_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b01;
    localparam logic [1:0] SZ_H = 2'b10;
    localparam logic [1:0] SZ_W = 2'b11;

    // Base strobes indexed by size code; code 00 aliases word.
    localparam logic [15:0] STRB_TBL = {4'b1111, 4'b0011, 4'b0001, 4'b1111};

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StWb
    } lsu_state_e;

    function automatic logic [1:0] norm_size(input logic [1:0] mask);
        return (mask == 2'b00) ? SZ_W : mask;
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        if (size == SZ_H) return off[0];
        if (size == SZ_W) return off != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/ysyx_25040111_lsu_if.sv
// Request/response data bus between the LSU (master) and memory (slave).
interface ysyx_25040111_lsu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [3:0]        req_wstrb;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ysyx_25040111_lsu_align.sv
// Byte-lane steering: store data/strobe shift toward the bus word and load extract/extend back.
module ysyx_25040111_lsu_align
    import ysyx_25040111_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_sign,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);
    logic [31:0] ld_shift;

    always_comb begin
        // Lanes shifted past byte 3 fall off the word.
        st_wstrb = STRB_TBL[{st_size, 2'b00} +: 4] << st_off;
        st_wdata = st_data << {st_off, 3'b000};
        ld_shift = ld_rdata >> {ld_off, 3'b000};
        case (norm_size(ld_size))
            SZ_B:    ld_data = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
            SZ_H:    ld_data = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/ysyx_25040111_lsu.sv
// Load/store stage: one instruction in flight, registered bus request and one writeback beat.
// Define YSYX_25040111_LSU_ALIGN_CHECK_EN to retire misaligned accesses as errors without bus traffic.
module ysyx_25040111_lsu
    import ysyx_25040111_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_men,
    input  logic                in_write,
    input  logic [31:0]         in_addr,
    input  logic [31:0]         in_wdata,
    input  logic [1:0]          in_mask,
    input  logic                in_rsign,
    input  logic [4:0]          in_ard,
    input  logic [31:0]         in_rd,
    input  logic                in_gen,
    input  logic [11:0]         in_acsr,
    input  logic [31:0]         in_csr,
    input  logic                in_sen,
    input  logic [31:0]         in_pc,
    ysyx_25040111_lsu_if.master mem,
    output logic                wb_valid,
    output logic [4:0]          wb_ard,
    output logic [31:0]         wb_rd,
    output logic                wb_gen,
    output logic [11:0]         wb_acsr,
    output logic [31:0]         wb_csr,
    output logic                wb_sen,
    output logic [31:0]         wb_pc,
    output logic                wb_err,
    output logic                finish,
    output logic [4:0]          frd
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    lsu_state_e       state_q;
    logic             men_q, write_q, rsign_q, gen_q, sen_q, err_q;
    logic [1:0]       off_q, size_q;
    logic [4:0]       ard_q;
    logic [31:0]      rd_q, csr_q, pc_q, rdata_q;
    logic [11:0]      acsr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0] st_wdata, ld_data, aligned_addr;
    logic [3:0]  st_wstrb;
    logic        in_misaligned;

    assign aligned_addr = {in_addr[31:2], 2'b00};
    assign finish       = wb_valid;
    assign frd          = wb_ard;

`ifdef YSYX_25040111_LSU_ALIGN_CHECK_EN
    assign in_misaligned = misaligned(norm_size(in_mask), in_addr[1:0]);
`else
    assign in_misaligned = 1'b0;
`endif

    ysyx_25040111_lsu_align u_align (
        .st_size  (in_mask),
        .st_off   (in_addr[1:0]),
        .st_data  (in_wdata),
        .st_wdata (st_wdata),
        .st_wstrb (st_wstrb),
        .ld_size  (size_q),
        .ld_off   (off_q),
        .ld_sign  (rsign_q),
        .ld_rdata (rdata_q),
        .ld_data  (ld_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            in_ready      <= 1'b1;
            men_q         <= 1'b0;
            write_q       <= 1'b0;
            rsign_q       <= 1'b0;
            gen_q         <= 1'b0;
            sen_q         <= 1'b0;
            err_q         <= 1'b0;
            off_q         <= '0;
            size_q        <= '0;
            ard_q         <= '0;
            rd_q          <= '0;
            csr_q         <= '0;
            pc_q          <= '0;
            rdata_q       <= '0;
            acsr_q        <= '0;
            cnt_q         <= '0;
            mem.req_valid <= 1'b0;
            mem.req_write <= 1'b0;
            mem.req_addr  <= '0;
            mem.req_wdata <= '0;
            mem.req_wstrb <= '0;
            wb_valid      <= 1'b0;
            wb_ard        <= '0;
            wb_rd         <= '0;
            wb_gen        <= 1'b0;
            wb_acsr       <= '0;
            wb_csr        <= '0;
            wb_sen        <= 1'b0;
            wb_pc         <= '0;
            wb_err        <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        men_q    <= in_men;
                        write_q  <= in_write;
                        off_q    <= in_addr[1:0];
                        size_q   <= norm_size(in_mask);
                        rsign_q  <= in_rsign;
                        ard_q    <= in_ard;
                        rd_q     <= in_rd;
                        gen_q    <= in_gen;
                        acsr_q   <= in_acsr;
                        csr_q    <= in_csr;
                        sen_q    <= in_sen;
                        pc_q     <= in_pc;
                        // Cleared so a timed-out or rejected load writes back zero.
                        rdata_q  <= '0;
                        if (in_men && !in_misaligned) begin
                            state_q       <= StReq;
                            err_q         <= 1'b0;
                            mem.req_valid <= 1'b1;
                            mem.req_write <= in_write;
                            mem.req_addr  <= aligned_addr[ADDR_W-1:0];
                            mem.req_wdata <= st_wdata;
                            mem.req_wstrb <= st_wstrb;
                        end else begin
                            state_q <= StWb;
                            err_q   <= in_men & in_misaligned;
                        end
                    end
                end
                StReq: begin
                    if (mem.req_ready) begin
                        mem.req_valid <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= StResp;
                    end
                end
                StResp: begin
                    if (mem.rsp_valid) begin
                        rdata_q <= mem.rsp_rdata;
                        err_q   <= mem.rsp_err;
                        state_q <= StWb;
                    end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                        // Waited TIMEOUT_CYC cycles without a response.
                        err_q   <= 1'b1;
                        state_q <= StWb;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWb: begin
                    wb_valid <= 1'b1;
                    wb_ard   <= ard_q;
                    wb_rd    <= (men_q && !write_q) ? ld_data : rd_q;
                    wb_gen   <= gen_q & ~err_q & ~(men_q & write_q);
                    wb_acsr  <= acsr_q;
                    wb_csr   <= csr_q;
                    wb_sen   <= sen_q & ~err_q;
                    wb_pc    <= pc_q;
                    wb_err   <= err_q;
                    in_ready <= 1'b1;
                    state_q  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Scoreboard bench for ysyx_25040111_lsu with a hand-driven memory and TIMEOUT_CYC=8.
module tb_ysyx_25040111_lsu;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct packed {
        logic [4:0]  ard;
        logic [31:0] rd;
        logic        gen;
        logic [11:0] acsr;
        logic [31:0] csr;
        logic        sen;
        logic [31:0] pc;
        logic        err;
    } wb_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_men, in_write, in_rsign, in_gen, in_sen;
    logic [31:0] in_addr, in_wdata, in_rd, in_csr, in_pc;
    logic [1:0]  in_mask;
    logic [4:0]  in_ard;
    logic [11:0] in_acsr;
    logic        wb_valid, wb_gen, wb_sen, wb_err, finish;
    logic [4:0]  wb_ard, frd;
    logic [31:0] wb_rd, wb_csr, wb_pc;
    logic [11:0] wb_acsr;

    int n_tests = 0;
    int n_fail  = 0;
    int wb_seen = 0;
    req_t req_q[$];
    wb_t  wb_q[$];

    always #5 clock = ~clock;

    ysyx_25040111_lsu_if #(.ADDR_W(32)) bus ();

    ysyx_25040111_lsu #(
        .TIMEOUT_CYC (8),
        .ADDR_W      (32)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_men   (in_men),
        .in_write (in_write),
        .in_addr  (in_addr),
        .in_wdata (in_wdata),
        .in_mask  (in_mask),
        .in_rsign (in_rsign),
        .in_ard   (in_ard),
        .in_rd    (in_rd),
        .in_gen   (in_gen),
        .in_acsr  (in_acsr),
        .in_csr   (in_csr),
        .in_sen   (in_sen),
        .in_pc    (in_pc),
        .mem      (bus),
        .wb_valid (wb_valid),
        .wb_ard   (wb_ard),
        .wb_rd    (wb_rd),
        .wb_gen   (wb_gen),
        .wb_acsr  (wb_acsr),
        .wb_csr   (wb_csr),
        .wb_sen   (wb_sen),
        .wb_pc    (wb_pc),
        .wb_err   (wb_err),
        .finish   (finish),
        .frd      (frd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_req(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb);
        req_t r;
        r.write = write;
        r.addr  = addr;
        r.wdata = wdata;
        r.wstrb = wstrb;
        req_q.push_back(r);
    endtask

    // CSR fields are derived from the PC so every op carries distinct values.
    task automatic push_wb(input logic [4:0] ard, input logic [31:0] rd, input logic gen,
                           input logic sen, input logic [31:0] pc, input logic err);
        wb_t e;
        e.ard  = ard;
        e.rd   = rd;
        e.gen  = gen;
        e.acsr = pc[13:2];
        e.csr  = ~pc;
        e.sen  = sen;
        e.pc   = pc;
        e.err  = err;
        wb_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.req_valid && bus.req_ready) begin
                if (req_q.size() == 0) begin
                    check("req_unexpected", 32'd1, 32'd0);
                end else begin
                    req_t r;
                    r = req_q.pop_front();
                    check("req_write", 32'(bus.req_write), 32'(r.write));
                    check("req_addr", bus.req_addr, r.addr);
                    check("req_wdata", bus.req_wdata, r.wdata);
                    check("req_wstrb", 32'(bus.req_wstrb), 32'(r.wstrb));
                end
            end
            if (wb_valid) begin
                wb_seen++;
                if (wb_q.size() == 0) begin
                    check("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    check("wb_ard", 32'(wb_ard), 32'(e.ard));
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_gen", 32'(wb_gen), 32'(e.gen));
                    check("wb_acsr", 32'(wb_acsr), 32'(e.acsr));
                    check("wb_csr", wb_csr, e.csr);
                    check("wb_sen", 32'(wb_sen), 32'(e.sen));
                    check("wb_pc", wb_pc, e.pc);
                    check("wb_err", 32'(wb_err), 32'(e.err));
                    check("finish", 32'(finish), 32'd1);
                    check("frd", 32'(frd), 32'(e.ard));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic men, input logic write, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] mask, input logic rsign,
                        input logic [4:0] ard, input logic [31:0] rd, input logic gen,
                        input logic sen, input logic [31:0] pc);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd0, 32'd1);
        in_men   = men;
        in_write = write;
        in_addr  = addr;
        in_wdata = wdata;
        in_mask  = mask;
        in_rsign = rsign;
        in_ard   = ard;
        in_rd    = rd;
        in_gen   = gen;
        in_sen   = sen;
        in_pc    = pc;
        in_acsr  = pc[13:2];
        in_csr   = ~pc;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic mem_accept(input int stall);
        int n = 0;
        while (!bus.req_valid && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        if (!bus.req_valid) begin
            check("req_timeout", 32'd0, 32'd1);
            return;
        end
        repeat (stall) begin
            @(negedge clock);
            check("stall_valid", 32'(bus.req_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            if (req_q.size() != 0) begin
                check("stall_addr", bus.req_addr, req_q[0].addr);
                check("stall_wdata", bus.req_wdata, req_q[0].wdata);
                check("stall_wstrb", 32'(bus.req_wstrb), 32'(req_q[0].wstrb));
            end
            @(posedge clock); #1;
        end
        bus.req_ready = 1'b1;
        @(posedge clock); #1;
        bus.req_ready = 1'b0;
    endtask

    task automatic mem_respond(input int lat, input logic [31:0] data, input logic err);
        repeat (lat) begin
            @(posedge clock); #1;
        end
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = data;
        bus.rsp_err   = err;
        @(posedge clock); #1;
        bus.rsp_valid = 1'b0;
        bus.rsp_err   = 1'b0;
    endtask

    task automatic wait_wb(input int target);
        int n = 0;
        while (wb_seen < target && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        check("wb_arrive", 32'(wb_seen), 32'(target));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        {in_valid, in_men, in_write, in_rsign, in_gen, in_sen} = '0;
        {in_addr, in_wdata, in_rd, in_csr, in_pc} = '0;
        in_mask = '0;
        in_ard  = '0;
        in_acsr = '0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        #1 reset = 1'b1;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_finish", 32'(finish), 32'd0);
        check("rst_req_valid", 32'(bus.req_valid), 32'd0);
        check("rst_wb_rd", wb_rd, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Non-memory op: wb_valid in the second cycle after the accepting cycle.
        push_wb(5'd5, 32'h0000_1234, 1'b1, 1'b1, 32'h8000_0000, 1'b0);
        send(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd5, 32'h0000_1234, 1'b1, 1'b1,
             32'h8000_0000);
        @(negedge clock);
        check("nm_lat_c1", 32'(wb_valid), 32'd0);
        check("nm_no_req_c1", 32'(bus.req_valid), 32'd0);
        check("nm_in_ready_c1", 32'(in_ready), 32'd0);
        @(negedge clock);
        check("nm_lat_c2", 32'(wb_valid), 32'd1);
        check("nm_no_req_c2", 32'(bus.req_valid), 32'd0);
        @(posedge clock); #1;
        wait_wb(1);

        // Store byte at offset 3.
        push_req(1'b1, 32'h8000_0000, 32'hAB00_0000, 4'b1000);
        push_wb(5'd7, 32'h0000_0055, 1'b0, 1'b0, 32'h8000_0004, 1'b0);
        send(1'b1, 1'b1, 32'h8000_0003, 32'h0000_00AB, 2'b01, 1'b0, 5'd7, 32'h55, 1'b1, 1'b0,
             32'h8000_0004);
        mem_accept(0);
        mem_respond(0, 32'hFFFF_FFFF, 1'b0);
        wait_wb(2);

        // Load half signed / unsigned at offset 2.
        push_req(1'b0, 32'h8000_0000, 32'h0, 4'b1100);
        push_wb(5'd10, 32'hFFFF_8001, 1'b1, 1'b0, 32'h8000_0008, 1'b0);
        send(1'b1, 1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b1, 5'd10, 32'h0, 1'b1, 1'b0,
             32'h8000_0008);
        mem_accept(0);
        mem_respond(1, 32'h8001_FFFF, 1'b0);
        wait_wb(3);

        push_req(1'b0, 32'h8000_0000, 32'h0, 4'b1100);
        push_wb(5'd10, 32'h0000_8001, 1'b1, 1'b0, 32'h8000_000C, 1'b0);
        send(1'b1, 1'b0, 32'h8000_0002, 32'h0, 2'b10, 1'b0, 5'd10, 32'h0, 1'b1, 1'b0,
             32'h8000_000C);
        mem_accept(0);
        mem_respond(2, 32'h8001_FFFF, 1'b0);
        wait_wb(4);

        // Store word with the bus stalling for 5 cycles; CSR write survives a store.
        push_req(1'b1, 32'h8000_1008, 32'h1122_3344, 4'b1111);
        push_wb(5'd11, 32'h0000_0099, 1'b0, 1'b1, 32'h8000_0010, 1'b0);
        send(1'b1, 1'b1, 32'h8000_1008, 32'h1122_3344, 2'b11, 1'b0, 5'd11, 32'h99, 1'b1, 1'b1,
             32'h8000_0010);
        mem_accept(5);
        mem_respond(0, 32'h0, 1'b0);
        wait_wb(5);

        // Load byte unsigned at offset 1.
        push_req(1'b0, 32'h0000_0100, 32'h0, 4'b0010);
        push_wb(5'd12, 32'h0000_0056, 1'b1, 1'b0, 32'h8000_0014, 1'b0);
        send(1'b1, 1'b0, 32'h0000_0101, 32'h0, 2'b01, 1'b0, 5'd12, 32'h0, 1'b1, 1'b0,
             32'h8000_0014);
        mem_accept(0);
        mem_respond(0, 32'h1234_5678, 1'b0);
        wait_wb(6);

        // Size code 00 behaves as a word.
        push_req(1'b0, 32'h0000_0020, 32'h0, 4'b1111);
        push_wb(5'd13, 32'hCAFE_BABE, 1'b1, 1'b0, 32'h8000_0018, 1'b0);
        send(1'b1, 1'b0, 32'h0000_0020, 32'h0, 2'b00, 1'b0, 5'd13, 32'h0, 1'b1, 1'b0,
             32'h8000_0018);
        mem_accept(0);
        mem_respond(0, 32'hCAFE_BABE, 1'b0);
        wait_wb(7);

        // Load byte signed at offset 2.
        push_req(1'b0, 32'h0000_0030, 32'h0, 4'b0100);
        push_wb(5'd14, 32'hFFFF_FF80, 1'b1, 1'b0, 32'h8000_001C, 1'b0);
        send(1'b1, 1'b0, 32'h0000_0032, 32'h0, 2'b01, 1'b1, 5'd14, 32'h0, 1'b1, 1'b0,
             32'h8000_001C);
        mem_accept(0);
        mem_respond(1, 32'h0080_0000, 1'b0);
        wait_wb(8);

        // Bus error kills both register-file writes.
        push_req(1'b0, 32'h0000_0040, 32'h0, 4'b1111);
        push_wb(5'd15, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h8000_0020, 1'b1);
        send(1'b1, 1'b0, 32'h0000_0040, 32'h0, 2'b11, 1'b0, 5'd15, 32'h0, 1'b1, 1'b1,
             32'h8000_0020);
        mem_accept(0);
        mem_respond(0, 32'h0BAD_F00D, 1'b1);
        wait_wb(9);

        // Misaligned half store is issued as-is; the upper lane is truncated.
        push_req(1'b1, 32'h0000_0000, 32'hEF00_0000, 4'b1000);
        push_wb(5'd16, 32'h0000_0077, 1'b0, 1'b0, 32'h8000_0024, 1'b0);
        send(1'b1, 1'b1, 32'h0000_0003, 32'h0000_BEEF, 2'b10, 1'b0, 5'd16, 32'h77, 1'b1, 1'b0,
             32'h8000_0024);
        mem_accept(0);
        mem_respond(0, 32'h0, 1'b0);
        wait_wb(10);

        // No response: RESP lasts 8 cycles, one WB cycle, then the error beat.
        push_req(1'b0, 32'h0000_0080, 32'h0, 4'b1111);
        push_wb(5'd3, 32'h0, 1'b0, 1'b0, 32'h8000_0028, 1'b1);
        send(1'b1, 1'b0, 32'h0000_0080, 32'h0, 2'b11, 1'b0, 5'd3, 32'h0, 1'b1, 1'b1,
             32'h8000_0028);
        mem_accept(0);
        for (int j = 0; j < 10; j++) begin
            @(negedge clock);
            check($sformatf("timeout_wb_c%0d", j), 32'(wb_valid), (j == 9) ? 32'd1 : 32'd0);
            @(posedge clock); #1;
        end
        wait_wb(11);

        // Reset while waiting in RESP clears outputs at once.
        push_req(1'b0, 32'h0000_0100, 32'h0, 4'b1111);
        send(1'b1, 1'b0, 32'h0000_0100, 32'h0, 2'b11, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0,
             32'h8000_002C);
        mem_accept(0);
        #2 reset = 1'b1;
        #1;
        check("arst_wb_err", 32'(wb_err), 32'd0);
        check("arst_wb_pc", wb_pc, 32'd0);
        check("arst_wb_csr", wb_csr, 32'd0);
        check("arst_wb_ard", 32'(wb_ard), 32'd0);
        check("arst_frd", 32'(frd), 32'd0);
        check("arst_req_valid", 32'(bus.req_valid), 32'd0);
        check("arst_req_addr", bus.req_addr, 32'd0);
        check("arst_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clock); #1;

        push_req(1'b0, 32'h0000_0104, 32'h0, 4'b1111);
        push_wb(5'd9, 32'h600D_CAFE, 1'b1, 1'b0, 32'h8000_0030, 1'b0);
        send(1'b1, 1'b0, 32'h0000_0104, 32'h0, 2'b11, 1'b0, 5'd9, 32'h0, 1'b1, 1'b0,
             32'h8000_0030);
        mem_accept(0);
        mem_respond(0, 32'h600D_CAFE, 1'b0);
        wait_wb(12);

        repeat (3) @(posedge clock);
        check("sb_req_empty", 32'(req_q.size()), 32'd0);
        check("sb_wb_empty", 32'(wb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
